// File: rtl/fp_accum.sv
// Single-precision stream accumulator wrapped around an external combinational FP adder.
// Optional build macro FP_ACCUM_ZERO_SKIP_EN keeps zero/denormal samples out of the adder.
module fp_accum #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_data,
  output logic [31:0]      o_add_a,
  output logic [31:0]      o_add_b,
  input  logic [31:0]      i_add_result,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_result,
  output logic [CNT_W-1:0] o_count,
  output logic             o_busy
);

  typedef enum logic [1:0] {StIdle, StLoad, StAcc, StDone} state_e;

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] len_q, len_d;

`ifdef FP_ACCUM_ZERO_SKIP_EN
  logic zero_q, zero_d;
  logic data_zero;
  assign data_zero = (i_data[30:23] == 8'h00);
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    len_d   = len_q;
`ifdef FP_ACCUM_ZERO_SKIP_EN
    zero_d  = zero_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          count_d = '0;
`ifdef FP_ACCUM_ZERO_SKIP_EN
          zero_d  = 1'b0;
`endif
          if (i_len == '0) begin
            acc_d   = 32'h0000_0000;
            state_d = StDone;
          end else begin
            len_d   = i_len;
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (i_valid) begin
          // First sample seeds the accumulator directly; the adder output is ignored.
          acc_d   = i_data;
          count_d = CNT_W'(1);
`ifdef FP_ACCUM_ZERO_SKIP_EN
          zero_d  = data_zero;
`endif
          state_d = (len_q == CNT_W'(1)) ? StDone : StAcc;
        end
      end
      StAcc: begin
        if (i_valid) begin
          count_d = count_q + CNT_W'(1);
`ifdef FP_ACCUM_ZERO_SKIP_EN
          // A zero-exponent sample never reaches the adder; a zero acc is replaced, not summed.
          if (!data_zero) begin
            if (zero_q) begin
              acc_d  = i_data;
              zero_d = 1'b0;
            end else begin
              acc_d  = i_add_result;
            end
          end
`else
          acc_d   = i_add_result;
`endif
          if (count_d == len_q) state_d = StDone;
        end
      end
      StDone: begin
        if (i_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      acc_q   <= 32'h0000_0000;
      count_q <= '0;
      len_q   <= '0;
`ifdef FP_ACCUM_ZERO_SKIP_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      len_q   <= len_d;
`ifdef FP_ACCUM_ZERO_SKIP_EN
      zero_q  <= zero_d;
`endif
    end
  end

  assign o_ready  = (state_q == StLoad) || (state_q == StAcc);
  assign o_valid  = (state_q == StDone);
  assign o_busy   = (state_q != StIdle);
  assign o_result = acc_q;
  assign o_add_a  = acc_q;
  assign o_add_b  = i_data;
  assign o_count  = count_q;

endmodule

// File: doc/fp_accum.md
# fp_accum

Sequential IEEE 754 single-precision stream accumulator that sits directly around the combinational floating-point adder stage. It accepts a length-tagged burst of 32-bit samples over a valid/ready handshake, drives the running sum and the incoming sample into the adder, and registers the adder's result back as the new running sum. After the burst it presents the final sum downstream on a valid/ready handshake. It owns all sequencing, zero handling and flow control; the arithmetic stays in the adder.

## Interface
- CNT_W, default 8: width of the burst length and sample counter; bursts are 0 to 2^CNT_W-1 samples.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_start  in  1  burst start pulse; sampled only in IDLE.
- i_len  in  CNT_W  number of samples in the burst; captured with i_start.
- i_valid  in  1  input sample valid.
- o_ready  out  1  block accepts a sample this cycle.
- i_data  in  32  input sample, IEEE 754 single.
- o_add_a  out  32  adder operand A, always the accumulator register.
- o_add_b  out  32  adder operand B, always i_data (combinational pass-through).
- i_add_result  in  32  adder sum of o_add_a and o_add_b, same cycle.
- o_valid  out  1  final sum valid.
- i_ready  in  1  downstream accepts the final sum.
- o_result  out  32  final sum; equals the accumulator register.
- o_count  out  CNT_W  samples accepted in the current burst.
- o_busy  out  1  high in any state other than IDLE.

## Operation
- A sample is accepted when i_valid && o_ready. A result is consumed when o_valid && i_ready.
- FSM states: IDLE, LOAD, ACC, DONE. Reset enters IDLE from any state, including mid-burst or mid-DONE. The partial sum is discarded.
- IDLE: o_ready=0. On i_start with i_len=0, clear acc to 0x00000000 and go to DONE. On i_start with i_len>0, capture i_len, clear o_count, and go to LOAD.
- LOAD: o_ready=1. On accept, acc <= i_data with no adder use, and o_count <= 1. If i_len=1 go to DONE, otherwise go to ACC.
- ACC: o_ready=1. On accept, acc <= i_add_result and o_count increments. When o_count reaches i_len go to DONE.
- DONE: o_ready=0 and o_valid=1. o_result is held stable until i_ready, then the FSM returns to IDLE.
- i_start outside IDLE is ignored. i_valid in IDLE or DONE is ignored, because no accept occurs.
- o_add_a and o_add_b are driven in every state. The block never registers i_data other than into acc.

## Timing
- Reset values: o_ready=0, o_valid=0, o_busy=0, o_count=0, o_result=0x00000000, o_add_a=0x00000000.
- Throughput: one sample per cycle in LOAD and ACC.
- Combinational path: i_data → o_add_b → adder → i_add_result → acc D-input, all in one cycle.
- Latency: o_valid rises in the cycle after the last sample is accepted.
- len=0: o_valid rises in the cycle after i_start.
- Back-to-back bursts: in the best case, i_start may assert in the cycle after the DONE handshake completes.

## Configuration
- FP_ACCUM_ZERO_SKIP_EN: when defined, samples whose exponent field is 0x00 (zero or denormal) are not sent through the adder.
  - In ACC, such a sample leaves acc unchanged, but o_count still increments.
  - A zero flag is set when LOAD captures a zero-exponent sample. While the flag is set, the next nonzero sample is loaded directly into acc, and the flag is then cleared.
  - Purpose: the adder applies an implicit leading 1 to every operand, including zero and denormal operands, so this path keeps zeros out of it.
- When not defined, every sample in ACC updates acc with i_add_result unconditionally.

## Test plan
- Reset mid-burst: hold i_rst_n=0 for 1 cycle during ACC → FSM returns to IDLE, every output is at its reset value, and o_count=0.
- Basic burst: i_len=3 with samples 0x3F800000, 0x3F800000, 0x40000000, no stalls → o_valid one cycle after the third accept, o_result=0x40800000 (4.0), o_count=3.
- Input gaps and output backpressure: same burst with i_valid low for 2 cycles between samples, and i_ready held low 5 cycles in DONE → o_result stays 0x40800000 throughout, then IDLE the cycle after i_ready=1.
- len=0 and len=1:
  - i_len=0 → o_result=0x00000000 with o_valid in the cycle after i_start.
  - i_len=1 with sample 0x3FC00000 → o_result=0x3FC00000 and the adder result is unused.
- Zero skip (macro defined): i_len=3 with samples 0x00000000, 0x3F800000, 0x3F000000 → o_result=0x3FC00000 (1.5), o_count=3. Also, i_start during ACC is ignored.
